grid_line_clear: RTL and testbench



---
 rtl/grid_line_clear_if.sv | 34 +++
 rtl/grid_line_clear.sv | 208 ++++++++++++++++++++
 tb/tb_grid_line_clear.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_line_clear_if.sv
// Port-A grid memory bus plus the start/busy/done handshake of the line-clear engine.
// The master side is the engine, the slave side is the game controller and memory.
interface grid_line_clear_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;
    logic [7:0] grid_addr;
    logic [7:0] grid_data_out;
    logic       grid_we;
    logic [7:0] grid_q;

    modport master (
        input  start,
        input  grid_q,
        output busy,
        output done,
        output lines_cleared,
        output grid_addr,
        output grid_data_out,
        output grid_we
    );

    modport slave (
        output start,
        output grid_q,
        input  busy,
        input  done,
        input  lines_cleared,
        input  grid_addr,
        input  grid_data_out,
        input  grid_we
    );
endinterface

// File: rtl/grid_line_clear.sv
// Tetris line-clear engine: scans rows bottom-up over grid memory port A, removes every
// full row by shifting the rows above it down one row and zeroing row 0.
module grid_line_clear #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic               clk,
    input  logic               reset,
    grid_line_clear_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_SHIFT_RD = 3'd2,
        S_SHIFT_WR = 3'd3,
        S_CLEAR    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [3:0] LAST_COL  = 4'(COLS - 1);
    localparam logic [3:0] DRAIN_COL = 4'(COLS);

    // Address arithmetic is built for the 10-column playfield: row*10 = row*8 + row*2.
    function automatic logic [7:0] cell_addr(input logic [4:0] row, input logic [3:0] col);
        logic [7:0] row_w;
        row_w = {3'b000, row};
        return (row_w << 3) + (row_w << 1) + {4'b0000, col};
    endfunction

    state_t     state_q, state_d;
    logic [4:0] row_q,   row_d;
    logic [4:0] dst_q,   dst_d;
    logic [3:0] col_q,   col_d;
    logic       full_q,  full_d;
    logic [4:0] lines_q, lines_d;
    logic [7:0] addr_q,  addr_d;
    logic       we_q,    we_d;
    logic       pass_q,  pass_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    logic cell_full_s;
    logic row_full_s;

    assign cell_full_s = (bus.grid_q != 8'h00);
    assign row_full_s  = full_q & cell_full_s;

    // Next-state and next-output logic; outputs are precomputed for the following cycle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        dst_d   = dst_q;
        col_d   = col_q;
        full_d  = full_q;
        lines_d = lines_q;
        addr_d  = 8'h00;
        we_d    = 1'b0;
        pass_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = S_CHECK;
                    row_d   = LAST_ROW;
                    col_d   = 4'd0;
                    full_d  = 1'b1;
                    lines_d = 5'd0;
                    addr_d  = cell_addr(LAST_ROW, 4'd0);
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            // col_q counts issue cycles; read data lags one cycle, so col 0 has no data yet.
            S_CHECK: begin
                busy_d = 1'b1;
                if (col_q != DRAIN_COL) begin
                    col_d  = col_q + 4'd1;
                    full_d = (col_q != 4'd0) ? row_full_s : full_q;
                    if (col_q != LAST_COL) begin
                        addr_d = cell_addr(row_q, col_q + 4'd1);
                    end else begin
                        addr_d = 8'h00;
                    end
                end else if (row_full_s) begin
                    lines_d = (lines_q == 5'd31) ? lines_q : lines_q + 5'd1;
                    dst_d   = row_q;
                    col_d   = 4'd0;
                    if (row_q != 5'd0) begin
                        state_d = S_SHIFT_RD;
                        addr_d  = cell_addr(row_q - 5'd1, 4'd0);
                    end else begin
                        state_d = S_CLEAR;
                        addr_d  = 8'h00;
                        we_d    = 1'b1;
                    end
                end else if (row_q != 5'd0) begin
                    row_d  = row_q - 5'd1;
                    col_d  = 4'd0;
                    full_d = 1'b1;
                    addr_d = cell_addr(row_q - 5'd1, 4'd0);
                end else begin
                    state_d = S_DONE;
                    col_d   = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            S_SHIFT_RD: begin
                busy_d  = 1'b1;
                state_d = S_SHIFT_WR;
                addr_d  = cell_addr(dst_q, col_q);
                we_d    = 1'b1;
                pass_d  = 1'b1;
            end

            S_SHIFT_WR: begin
                busy_d = 1'b1;
                if (col_q != LAST_COL) begin
                    state_d = S_SHIFT_RD;
                    col_d   = col_q + 4'd1;
                    addr_d  = cell_addr(dst_q - 5'd1, col_q + 4'd1);
                end else if (dst_q != 5'd1) begin
                    state_d = S_SHIFT_RD;
                    dst_d   = dst_q - 5'd1;
                    col_d   = 4'd0;
                    addr_d  = cell_addr(dst_q - 5'd2, 4'd0);
                end else begin
                    state_d = S_CLEAR;
                    dst_d   = 5'd0;
                    col_d   = 4'd0;
                    addr_d  = 8'h00;
                    we_d    = 1'b1;
                end
            end

            // After zeroing row 0 the same row is checked again: new content has dropped into it.
            S_CLEAR: begin
                busy_d = 1'b1;
                if (col_q != LAST_COL) begin
                    col_d  = col_q + 4'd1;
                    addr_d = {4'b0000, col_q + 4'd1};
                    we_d   = 1'b1;
                end else begin
                    state_d = S_CHECK;
                    col_d   = 4'd0;
                    full_d  = 1'b1;
                    addr_d  = cell_addr(row_q, 4'd0);
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts a pass and drops the write enable at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= 5'd0;
            dst_q   <= 5'd0;
            col_q   <= 4'd0;
            full_q  <= 1'b0;
            lines_q <= 5'd0;
            addr_q  <= 8'h00;
            we_q    <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            dst_q   <= dst_d;
            col_q   <= col_d;
            full_q  <= full_d;
            lines_q <= lines_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Read data only arrives in the write cycle itself, so the copy path goes straight through.
    assign bus.grid_data_out = pass_q ? bus.grid_q : 8'h00;
    assign bus.grid_addr     = addr_q;
    assign bus.grid_we       = we_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.lines_cleared = lines_q;

endmodule

// File: tb/tb_grid_line_clear.sv
// Scoreboard bench for grid_line_clear: a row-level model predicts lines, pass length,
// write count and final grid for each start; results are checked when done pulses.
module tb_grid_line_clear;

    typedef struct packed {
        int lines;
        int cycles;
        int writes;
        int maxaddr;
    } exp_t;

    logic clk;
    logic reset;
    logic load;

    logic [7:0] mem      [0:255];
    logic [7:0] img      [0:199];
    logic [7:0] exp_grid [0:199];

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    grid_line_clear_if bus ();

    grid_line_clear #(.COLS(10), .ROWS(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous port-A memory: one-cycle read latency, write on grid_we.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 200; i++) mem[i] <= img[i];
        end else if (bus.grid_we) begin
            mem[bus.grid_addr] <= bus.grid_data_out;
        end
        bus.grid_q <= mem[bus.grid_addr];
    end

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 200; i++) img[i] = 8'h00;
    endtask

    task automatic fill_row(input int r, input logic [7:0] v);
        for (int c = 0; c < 10; c++) img[r*10 + c] = v;
    endtask

    // Row-level model of a full pass: costs, writes and resulting grid.
    task automatic model(output exp_t e);
        int r;
        bit full;
        for (int i = 0; i < 200; i++) exp_grid[i] = img[i];
        e = '{0, 0, 0, 0};
        r = 19;
        forever begin
            full = 1'b1;
            for (int c = 0; c < 10; c++) if (exp_grid[r*10 + c] == 8'h00) full = 1'b0;
            e.cycles += 11;
            if (full) begin
                if (e.lines < 31) e.lines++;
                e.cycles += 20*r + 10;
                e.writes += 10*r + 10;
                if (r*10 + 9 > e.maxaddr) e.maxaddr = r*10 + 9;
                for (int d = r; d > 0; d--)
                    for (int c = 0; c < 10; c++) exp_grid[d*10 + c] = exp_grid[(d-1)*10 + c];
                for (int c = 0; c < 10; c++) exp_grid[c] = 8'h00;
            end else if (r == 0) begin
                break;
            end else begin
                r--;
            end
        end
        e.cycles += 1;
    endtask

    task automatic load_img();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic run_pass(input string name, input bit poke, output int got_cycles);
        exp_t e;
        exp_t m;
        int   cyc;
        int   wr;
        int   maxa;
        int   extra;
        bit   seen;
        logic [79:0] gv;
        logic [79:0] ev;
        load_img();
        model(m);
        @(negedge clk) bus.start = 1'b1;
        sb.push_back(m);
        @(negedge clk) bus.start = 1'b0;
        check_val({name, "_busy_c1"}, 80'(bus.busy), 80'd1);
        cyc = 1; wr = 0; maxa = 0; seen = 1'b0;
        while (cyc < 5000) begin
            if (bus.grid_we) begin
                wr++;
                if (int'(bus.grid_addr) > maxa) maxa = int'(bus.grid_addr);
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            bus.start = (poke && cyc == 40);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        got_cycles = cyc;
        check_val({name, "_done_seen"}, 80'(seen), 80'd1);
        e = sb.pop_front();
        check_val({name, "_lines"},   80'(bus.lines_cleared), 80'(e.lines));
        check_val({name, "_cycles"},  80'(cyc),  80'(e.cycles));
        check_val({name, "_writes"},  80'(wr),   80'(e.writes));
        check_val({name, "_maxaddr"}, 80'(maxa), 80'(e.maxaddr));
        check_val({name, "_busy_done"}, 80'(bus.busy), 80'd0);
        @(negedge clk);
        check_val({name, "_done_pulse"}, 80'(bus.done), 80'd0);
        if (poke) begin
            extra = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (bus.done) extra++;
            end
            check_val({name, "_extra_done"}, 80'(extra), 80'd0);
            check_val({name, "_lines_hold"}, 80'(bus.lines_cleared), 80'(e.lines));
        end
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 10; c++) begin
                gv[c*8 +: 8] = mem[r*10 + c];
                ev[c*8 +: 8] = exp_grid[r*10 + c];
            end
            check_val($sformatf("%s_row%0d", name, r), gv, ev);
        end
    endtask

    initial begin
        int cyc;
        bit hit;
        n_checks  = 0;
        n_fail    = 0;
        load      = 1'b0;
        bus.start = 1'b0;
        reset     = 1'b1;
        clear_img();
        #3;
        check_val("rst_busy", 80'(bus.busy), 80'd0);
        check_val("rst_done", 80'(bus.done), 80'd0);
        check_val("rst_lines", 80'(bus.lines_cleared), 80'd0);
        check_val("rst_addr", 80'(bus.grid_addr), 80'd0);
        check_val("rst_we", 80'(bus.grid_we), 80'd0);
        check_val("rst_dout", 80'(bus.grid_data_out), 80'd0);
        @(negedge clk) reset = 1'b0;

        clear_img();
        run_pass("empty", 1'b0, cyc);
        check_val("empty_221", 80'(cyc), 80'd221);

        clear_img();
        fill_row(19, 8'h01);
        img[18*10 + 0] = 8'h05;
        run_pass("one", 1'b0, cyc);
        check_val("one_622", 80'(cyc), 80'd622);
        check_val("one_cell_19_0", 80'(mem[190]), 80'h05);

        clear_img();
        fill_row(19, 8'h0A);
        fill_row(17, 8'h0C);
        img[18*10 + 4] = 8'h03;
        img[16*10 + 9] = 8'h07;
        run_pass("two", 1'b0, cyc);
        check_val("two_cell_19_4", 80'(mem[194]), 80'h03);
        check_val("two_cell_18_9", 80'(mem[189]), 80'h07);

        clear_img();
        for (int r = 16; r < 20; r++) for (int c = 0; c < 10; c++) img[r*10 + c] = 8'(r + c + 1);
        for (int c = 1; c < 10; c++) img[15*10 + c] = 8'h02;
        run_pass("tetris", 1'b0, cyc);
        check_val("tetris_lines", 80'(bus.lines_cleared), 80'd4);

        clear_img();
        fill_row(0, 8'hFF);
        run_pass("row0", 1'b0, cyc);
        check_val("row0_lines", 80'(bus.lines_cleared), 80'd1);

        clear_img();
        for (int r = 8; r < 20; r++) begin
            if ($urandom_range(0, 2) != 0) begin
                for (int c = 0; c < 10; c++) img[r*10 + c] = 8'($urandom_range(1, 255));
            end else begin
                for (int c = 0; c < 10; c++)
                    img[r*10 + c] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            end
        end
        run_pass("rand", 1'b0, cyc);

        clear_img();
        fill_row(19, 8'h01);
        img[18*10 + 0] = 8'h05;
        run_pass("poke", 1'b1, cyc);

        // Abort during a shift write and confirm the outputs drop without a clock edge.
        load_img();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.grid_we && bus.grid_addr >= 8'd10) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("rst_mid_shift_seen", 80'(hit), 80'd1);
        reset = 1'b1;
        #1;
        check_val("rst_mid_we", 80'(bus.grid_we), 80'd0);
        check_val("rst_mid_busy", 80'(bus.busy), 80'd0);
        check_val("rst_mid_addr", 80'(bus.grid_addr), 80'd0);
        @(negedge clk) reset = 1'b0;

        clear_img();
        fill_row(19, 8'h0A);
        fill_row(17, 8'h0C);
        img[18*10 + 4] = 8'h03;
        img[16*10 + 9] = 8'h07;
        run_pass("after_rst", 1'b0, cyc);

        check_val("sb_empty", 80'(sb.size()), 80'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
